// File: rtl/traffic_queue_sensor_if.sv
// Handshake bundle between the traffic queue sensor and its surroundings:
// arrivals and green feedback in, traffic-present flags, depths and drop flags out.
interface traffic_queue_sensor_if #(
    parameter int QW = 4
);
    logic          arr_a;
    logic          arr_b;
    logic          GA;
    logic          GB;
    logic          TA;
    logic          TB;
    logic [QW-1:0] count_a;
    logic [QW-1:0] count_b;
    logic          drop_a;
    logic          drop_b;

    modport master (
        output arr_a, arr_b, GA, GB,
        input  TA, TB, count_a, count_b, drop_a, drop_b
    );

    modport slave (
        input  arr_a, arr_b, GA, GB,
        output TA, TB, count_a, count_b, drop_a, drop_b
    );
endinterface

// File: rtl/traffic_queue_sensor.sv
// Per-road vehicle queue model feeding TA/TB to the traffic light controller.
// Define TRAFFIC_QUEUE_LFSR_ARRIVAL_EN to replace the arrival ports with an internal LFSR.
module traffic_queue_sensor #(
    parameter int QW      = 4,
    parameter int THRESH  = 1,
    parameter int DEP_GAP = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    traffic_queue_sensor_if.slave q_if
);
    localparam int            TW       = (DEP_GAP > 1) ? $clog2(DEP_GAP) : 1;
    localparam logic [QW-1:0] CNT_MAX  = '1;
    localparam logic [QW-1:0] THR      = QW'(THRESH);
    localparam logic [TW-1:0] TMR_LAST = TW'(DEP_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRAIN = 2'b01,
        EMPTY = 2'b10
    } state_e;

    logic [1:0] arr;
    logic [1:0] grn;

    assign grn = {q_if.GB, q_if.GA};

`ifdef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end

    assign arr = {lfsr_q[5] & lfsr_q[7], lfsr_q[0] & lfsr_q[3]};
`else
    assign arr = {q_if.arr_b, q_if.arr_a};
`endif

    for (genvar d = 0; d < 2; d++) begin : g_dir
        state_e        st_q;
        logic [TW-1:0] tmr_q, tmr_d;
        logic [QW-1:0] cnt_q, cnt_d;
        logic          t_q, t_d;
        logic          drop_q, drop_d;
        logic          dep;

        // The timer is held in EMPTY so a fresh arrival waits one cycle before the gap starts
        always_comb begin
            dep    = grn[d] && (cnt_q != '0) && (st_q != EMPTY) && (tmr_q == TMR_LAST);
            tmr_d  = (!grn[d] || (cnt_q == '0) || (st_q == EMPTY) || dep) ? '0 : tmr_q + 1'b1;
            cnt_d  = cnt_q;
            drop_d = drop_q;
            if (arr[d] && !dep) begin
                if (cnt_q == CNT_MAX) drop_d = 1'b1;
                else                  cnt_d  = cnt_q + 1'b1;
            end else if (dep && !arr[d]) begin
                cnt_d = cnt_q - 1'b1;
            end
            t_d = (cnt_d >= THR);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= IDLE;
                tmr_q  <= '0;
                cnt_q  <= '0;
                t_q    <= 1'b0;
                drop_q <= 1'b0;
            end else begin
                tmr_q  <= tmr_d;
                cnt_q  <= cnt_d;
                t_q    <= t_d;
                drop_q <= drop_d;
                case (st_q)
                    IDLE:    if (grn[d]) st_q <= (cnt_q != '0) ? DRAIN : EMPTY;
                    DRAIN:   if (!grn[d]) st_q <= IDLE;
                             else if (cnt_d == '0) st_q <= EMPTY;
                    EMPTY:   if (!grn[d]) st_q <= IDLE;
                             else if (cnt_q != '0) st_q <= DRAIN;
                    default: st_q <= IDLE;
                endcase
            end
        end
    end

    assign q_if.TA      = g_dir[0].t_q;
    assign q_if.TB      = g_dir[1].t_q;
    assign q_if.count_a = g_dir[0].cnt_q;
    assign q_if.count_b = g_dir[1].cnt_q;
    assign q_if.drop_a  = g_dir[0].drop_q;
    assign q_if.drop_b  = g_dir[1].drop_q;
endmodule

// File: tb/tb_traffic_queue_sensor.sv
// Bench for traffic_queue_sensor: two parameterisations driven in lockstep against
// a rule-level queue model, plus directed reset, drain, full-queue and mid-gap steps.
module tb_traffic_queue_sensor;
    localparam int QW   = 4;
    localparam int MAXC = (1 << QW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arr_a = 1'b0, arr_b = 1'b0, ga = 1'b0, gb = 1'b0;

    always #5 clk = ~clk;

    traffic_queue_sensor_if #(.QW(QW)) if0 ();
    traffic_queue_sensor_if #(.QW(QW)) if1 ();

    assign if0.arr_a = arr_a;
    assign if0.arr_b = arr_b;
    assign if0.GA    = ga;
    assign if0.GB    = gb;
    assign if1.arr_a = arr_a;
    assign if1.arr_b = arr_b;
    assign if1.GA    = ga;
    assign if1.GB    = gb;

    traffic_queue_sensor #(.QW(QW)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .q_if  (if0.slave)
    );

    traffic_queue_sensor #(.QW(QW), .THRESH(2), .DEP_GAP(3)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .q_if  (if1.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model, indexed [instance][direction]
    int       gap[2] = '{2, 3};
    int       thr[2] = '{1, 2};
    int       m_cnt[2][2];
    int       m_tmr[2][2];
    bit       m_drop[2][2];
    bit       m_t[2][2];
    bit       m_pg[2][2];
    bit       m_h[2][2];
    bit [7:0] m_lfsr;

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int d = 0; d < 2; d++) begin
                m_cnt[i][d] = 0; m_tmr[i][d] = 0; m_drop[i][d] = 0;
                m_t[i][d] = 0;   m_pg[i][d] = 0;  m_h[i][d] = 0;
            end
        m_lfsr = 8'hA5;
    endtask

    task automatic model_step();
        bit a[2];
        bit gg[2];
        bit dep, hold;
        int nc;
`ifdef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
        a[0] = m_lfsr[0] & m_lfsr[3];
        a[1] = m_lfsr[5] & m_lfsr[7];
`else
        a[0] = arr_a;
        a[1] = arr_b;
`endif
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        gg[0] = ga;
        gg[1] = gb;
        for (int i = 0; i < 2; i++)
            for (int d = 0; d < 2; d++) begin
                hold = m_pg[i][d] && m_h[i][d];
                dep  = gg[d] && (m_cnt[i][d] > 0) && !hold && (m_tmr[i][d] == gap[i] - 1);
                nc   = m_cnt[i][d];
                if (a[d] && !dep) begin
                    if (nc == MAXC) m_drop[i][d] = 1'b1;
                    else            nc++;
                end else if (dep && !a[d]) begin
                    nc--;
                end
                if (!gg[d])                         m_h[i][d] = 1'b0;
                else if (!m_pg[i][d] || m_h[i][d])  m_h[i][d] = (m_cnt[i][d] == 0);
                else                                m_h[i][d] = (nc == 0);
                m_tmr[i][d] = (!gg[d] || m_cnt[i][d] == 0 || hold || dep) ? 0 : m_tmr[i][d] + 1;
                m_pg[i][d]  = gg[d];
                m_cnt[i][d] = nc;
                m_t[i][d]   = (nc >= thr[i]);
            end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic chk_inst(input int i, input logic [QW-1:0] ca, input logic [QW-1:0] cb,
                            input logic ta, input logic tb, input logic da, input logic db);
        chk($sformatf("u%0d.count_a", i), 32'(ca), 32'(m_cnt[i][0]));
        chk($sformatf("u%0d.count_b", i), 32'(cb), 32'(m_cnt[i][1]));
        chk($sformatf("u%0d.TA", i),      32'(ta), 32'(m_t[i][0]));
        chk($sformatf("u%0d.TB", i),      32'(tb), 32'(m_t[i][1]));
        chk($sformatf("u%0d.drop_a", i),  32'(da), 32'(m_drop[i][0]));
        chk($sformatf("u%0d.drop_b", i),  32'(db), 32'(m_drop[i][1]));
    endtask

    task automatic check_all();
        chk_inst(0, if0.count_a, if0.count_b, if0.TA, if0.TB, if0.drop_a, if0.drop_b);
        chk_inst(1, if1.count_a, if1.count_b, if1.TA, if1.TB, if1.drop_a, if1.drop_b);
    endtask

    // Inputs change on the falling edge; the model follows each rising edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Arrivals on A with green off
        arr_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
`ifndef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
            chk("arrive.count_a", 32'(if0.count_a), 32'(k));
            chk("arrive.TA", 32'(if0.TA), 32'd1);
            chk("arrive.TB", 32'(if0.TB), 32'd0);
`endif
        end
        arr_a = 1'b0;

        // Drain A: departures every second cycle on u0
        ga = 1'b1;
        begin
            int exp_cnt[6] = '{3, 2, 2, 1, 1, 0};
            for (int k = 0; k < 6; k++) begin
                cyc();
`ifndef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
                chk("drain.count_a", 32'(if0.count_a), 32'(exp_cnt[k]));
`endif
            end
        end
`ifndef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
        chk("drain.TA_low", 32'(if0.TA), 32'd0);
`endif
        cyc();
        cyc();
        ga = 1'b0;
        cyc();

        // Build a queue, then reset between clock edges
        arr_a = 1'b1;
        repeat (5) cyc();
        arr_a = 1'b0;
        async_reset();
        chk("rst.count_a", 32'(if0.count_a), 32'd0);
        chk("rst.TA", 32'(if0.TA), 32'd0);
        chk("rst.drop_a", 32'(if0.drop_a), 32'd0);

        // Green drops mid-gap on u1 (three-cycle gap)
        arr_a = 1'b1;
        repeat (2) cyc();
        arr_a = 1'b0;
        ga = 1'b1;
        cyc();
        ga = 1'b0;
        cyc();
        ga = 1'b1;
        cyc();
        cyc();
`ifndef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
        chk("midgap.count_a_held", 32'(if1.count_a), 32'd2);
`endif
        cyc();
`ifndef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
        chk("midgap.count_a_dep", 32'(if1.count_a), 32'd1);
`endif
        ga = 1'b0;
        cyc();

        // Fill B, then coincide an arrival with a departure at full
        arr_b = 1'b1;
        repeat (MAXC) cyc();
`ifndef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
        chk("full.count_b", 32'(if0.count_b), 32'(MAXC));
`endif
        arr_b = 1'b0;
        gb = 1'b1;
        cyc();
        arr_b = 1'b1;
        cyc();
`ifndef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
        chk("coincide.count_b", 32'(if0.count_b), 32'(MAXC));
        chk("coincide.drop_b", 32'(if0.drop_b), 32'd0);
`endif
        cyc();
`ifndef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
        chk("overflow.count_b", 32'(if0.count_b), 32'(MAXC));
        chk("overflow.drop_b", 32'(if0.drop_b), 32'd1);
`endif
        arr_b = 1'b0;
        gb = 1'b0;
        repeat (2) cyc();
`ifndef TRAFFIC_QUEUE_LFSR_ARRIVAL_EN
        chk("sticky.drop_b", 32'(if0.drop_b), 32'd1);
`endif

        // Greens off, arrival ports toggling, 64 cycles from a fresh reset
        async_reset();
        for (int k = 0; k < 64; k++) begin
            arr_a = 1'($urandom_range(0, 1));
            arr_b = 1'($urandom_range(0, 1));
            cyc();
        end

        // Randomized traffic with occasional green changes (both greens may overlap)
        async_reset();
        for (int k = 0; k < 600; k++) begin
            arr_a = ($urandom_range(0, 2) == 0);
            arr_b = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) ga = ~ga;
            if ($urandom_range(0, 7) == 0) gb = ~gb;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
